// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer
// Write-side master for the frame buffer BRAM (port A of blk_mem_gen_0).
// Takes a pixel stream with a start-of-frame marker, writes pixels at
// sequential addresses 0..FRAME_PIXELS-1, flags completed and short frames
// and counts completed frames. The display path reads the other BRAM port.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   arm capture, only looked at while idle
//   s_data     in   pixel data (RGB444)
//   s_valid    in   pixel valid
//   s_sof      in   first pixel of a frame, qualified by s_valid
//   s_ready    out  writer can accept a pixel (constant 1 after reset)
//   wea        out  BRAM write enable, one cycle per written pixel
//   addra      out  BRAM write address
//   dina       out  BRAM write data
//   busy       out  high while a frame is being written
//   frame_done out  one-cycle pulse with the write of the last pixel
//   frame_err  out  one-cycle pulse when a new SOF cuts a frame short
//   frame_cnt  out  completed frames, wraps around
module frame_buffer_writer #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t state;
  state_t state_next;

  // idx is the address the next non-SOF pixel will be written to
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_next;

  logic                  wea_next;
  logic [ADDR_WIDTH-1:0] addra_next;
  logic [DATA_WIDTH-1:0] dina_next;
  logic                  done_next;
  logic                  err_next;
  logic [CNT_WIDTH-1:0]  cnt_next;

  logic accept;
  logic is_last;

  assign accept  = s_valid && s_ready;
  assign is_last = (idx == LAST_ADDR);

  // State register; busy is registered alongside so it tracks the state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == WRITE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && s_sof && enable) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // A SOF in WRITE restarts the frame, so only a plain last pixel exits
        if (accept && !s_sof && is_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered write port, pulses and counters
  always_comb begin
    wea_next   = 1'b0;
    addra_next = addra;
    dina_next  = dina;
    done_next  = 1'b0;
    err_next   = 1'b0;
    idx_next   = idx;
    cnt_next   = frame_cnt;
    case (state)
      IDLE: begin
        if (accept && s_sof && enable) begin
          wea_next   = 1'b1;
          addra_next = '0;
          dina_next  = s_data;
          idx_next   = ADDR_WIDTH'(1);
        end
      end
      WRITE: begin
        if (accept) begin
          wea_next  = 1'b1;
          dina_next = s_data;
          if (s_sof) begin
            // idx is never 0 while in WRITE, but keep the check explicit
            err_next   = (idx != '0);
            addra_next = '0;
            idx_next   = ADDR_WIDTH'(1);
          end else begin
            addra_next = idx;
            if (is_last) begin
              done_next = 1'b1;
              cnt_next  = frame_cnt + CNT_WIDTH'(1);
              idx_next  = '0;
            end else begin
              idx_next = idx + ADDR_WIDTH'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Registered write port, status pulses, counters and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
      idx        <= '0;
    end else begin
      s_ready    <= 1'b1;
      wea        <= wea_next;
      addra      <= addra_next;
      dina       <= dina_next;
      frame_done <= done_next;
      frame_err  <= err_next;
      frame_cnt  <= cnt_next;
      idx        <= idx_next;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer
// Directed bench for frame_buffer_writer. Instance a uses the full 320x240
// frame size for reset, start-of-frame, async reset and short-frame restart;
// instance b uses a 4-pixel frame so completion, gaps, enable gating and
// counter wrap-around can be exercised in few cycles.
module tb_frame_buffer_writer;

  logic        clk;
  logic        rst_n;

  logic        a_enable, a_valid, a_sof;
  logic [11:0] a_data;
  logic        a_ready, a_wea, a_busy, a_done, a_err;
  logic [16:0] a_addra;
  logic [11:0] a_dina;
  logic [7:0]  a_cnt;

  logic        b_enable, b_valid, b_sof;
  logic [11:0] b_data;
  logic        b_ready, b_wea, b_busy, b_done, b_err;
  logic [16:0] b_addra;
  logic [11:0] b_dina;
  logic [7:0]  b_cnt;

  int total;
  int bad;

  frame_buffer_writer dut_a (
    .clk(clk), .rst_n(rst_n), .enable(a_enable), .s_data(a_data),
    .s_valid(a_valid), .s_sof(a_sof), .s_ready(a_ready), .wea(a_wea),
    .addra(a_addra), .dina(a_dina), .busy(a_busy), .frame_done(a_done),
    .frame_err(a_err), .frame_cnt(a_cnt)
  );

  frame_buffer_writer #(
    .ADDR_WIDTH(17), .DATA_WIDTH(12), .FRAME_PIXELS(4), .CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .s_data(b_data),
    .s_valid(b_valid), .s_sof(b_sof), .s_ready(b_ready), .wea(b_wea),
    .addra(b_addra), .dina(b_dina), .busy(b_busy), .frame_done(b_done),
    .frame_err(b_err), .frame_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic wea, input logic [16:0] addr,
                             input logic [11:0] data, input logic done, input logic err,
                             input logic exp_wea, input int exp_addr, input int exp_data,
                             input logic exp_done, input logic exp_err);
    check_output({tag, ".wea"}, 32'(wea), 32'(exp_wea));
    check_output({tag, ".addra"}, 32'(addr), 32'(exp_addr));
    check_output({tag, ".dina"}, 32'(data), 32'(exp_data));
    check_output({tag, ".done"}, 32'(done), 32'(exp_done));
    check_output({tag, ".err"}, 32'(err), 32'(exp_err));
  endtask

  // Drive one cycle on an instance, then sample 1 time unit after the edge
  task automatic apply_stimulus_a(input logic valid, input logic sof, input logic [11:0] data);
    a_valid = valid;
    a_sof   = sof;
    a_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_b(input logic valid, input logic sof, input logic [11:0] data);
    b_valid = valid;
    b_sof   = sof;
    b_data  = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a_enable = 1'b0; a_valid = 1'b0; a_sof = 1'b0; a_data = '0;
    b_enable = 1'b0; b_valid = 1'b0; b_sof = 1'b0; b_data = '0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check_output("rst.a_ready", 32'(a_ready), 0);
    check_output("rst.a_busy", 32'(a_busy), 0);
    check_output("rst.a_cnt", 32'(a_cnt), 0);
    check_write("rst.a", a_wea, a_addra, a_dina, a_done, a_err, 0, 0, 0, 0, 0);
    check_output("rst.b_ready", 32'(b_ready), 0);
    check_write("rst.b", b_wea, b_addra, b_dina, b_done, b_err, 0, 0, 0, 0, 0);

    rst_n = 1'b1;
    #1;
    check_output("release.a_ready_before_edge", 32'(a_ready), 0);
    @(posedge clk);
    #1;
    check_output("release.a_ready", 32'(a_ready), 1);
    check_output("release.b_ready", 32'(b_ready), 1);
    apply_stimulus_a(1'b0, 1'b0, 12'h000);
    check_output("idle.a_wea", 32'(a_wea), 0);
    check_output("idle.a_ready", 32'(a_ready), 1);

    // Instance a: start a full-size frame, write addresses 0..9
    a_enable = 1'b1;
    apply_stimulus_a(1'b1, 1'b1, 12'hABC);
    check_write("a.sof", a_wea, a_addra, a_dina, a_done, a_err, 1, 0, 12'hABC, 0, 0);
    check_output("a.sof.busy", 32'(a_busy), 1);
    for (int i = 1; i < 10; i++) begin
      apply_stimulus_a(1'b1, 1'b0, 12'h100 + 12'(i));
      check_write("a.px", a_wea, a_addra, a_dina, a_done, a_err, 1, i, 12'h100 + i, 0, 0);
    end
    apply_stimulus_a(1'b0, 1'b0, 12'h000);
    check_write("a.gap", a_wea, a_addra, a_dina, a_done, a_err, 0, 9, 12'h109, 0, 0);
    check_output("a.gap.busy", 32'(a_busy), 1);

    // Async reset at index 10 takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check_write("a.async_rst", a_wea, a_addra, a_dina, a_done, a_err, 0, 0, 0, 0, 0);
    check_output("a.async_rst.busy", 32'(a_busy), 0);
    check_output("a.async_rst.ready", 32'(a_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("a.rerelease.ready", 32'(a_ready), 1);

    apply_stimulus_a(1'b1, 1'b1, 12'h055);
    check_write("a.restart", a_wea, a_addra, a_dina, a_done, a_err, 1, 0, 12'h055, 0, 0);
    for (int i = 1; i < 4; i++) begin
      apply_stimulus_a(1'b1, 1'b0, 12'h050 + 12'(i));
      check_write("a.restart_px", a_wea, a_addra, a_dina, a_done, a_err, 1, i, 12'h050 + i, 0, 0);
    end
    // SOF without valid is not accepted
    apply_stimulus_a(1'b0, 1'b1, 12'h999);
    check_write("a.sof_novalid", a_wea, a_addra, a_dina, a_done, a_err, 0, 3, 12'h053, 0, 0);
    // Short frame: SOF at index 4
    apply_stimulus_a(1'b1, 1'b1, 12'h777);
    check_write("a.short", a_wea, a_addra, a_dina, a_done, a_err, 1, 0, 12'h777, 0, 1);
    apply_stimulus_a(1'b1, 1'b0, 12'h778);
    check_write("a.after_short", a_wea, a_addra, a_dina, a_done, a_err, 1, 1, 12'h778, 0, 0);
    check_output("a.after_short.cnt", 32'(a_cnt), 0);
    apply_stimulus_a(1'b0, 1'b0, 12'h000);

    // Instance b: full 4-pixel frame back-to-back
    b_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus_b(1'b1, i == 0, 12'h200 + 12'(i));
      check_write("b.frame", b_wea, b_addra, b_dina, b_done, b_err, 1, i, 12'h200 + i, i == 3, 0);
    end
    check_output("b.frame.cnt", 32'(b_cnt), 1);
    apply_stimulus_b(1'b0, 1'b0, 12'h000);
    check_write("b.frame_after", b_wea, b_addra, b_dina, b_done, b_err, 0, 3, 12'h203, 0, 0);
    check_output("b.frame_after.busy", 32'(b_busy), 0);

    // Junk before SOF is discarded
    for (int k = 0; k < 5; k++) begin
      apply_stimulus_b(1'b1, 1'b0, 12'hF00 + 12'(k));
      check_output("b.junk.wea", 32'(b_wea), 0);
    end

    // Frame with a gap after every pixel
    for (int i = 0; i < 4; i++) begin
      apply_stimulus_b(1'b1, i == 0, 12'h300 + 12'(i));
      check_write("b.gapped", b_wea, b_addra, b_dina, b_done, b_err, 1, i, 12'h300 + i, i == 3, 0);
      apply_stimulus_b(1'b0, 1'b0, 12'h000);
      check_write("b.gapped_idle", b_wea, b_addra, b_dina, b_done, b_err, 0, i, 12'h300 + i, 0, 0);
    end
    check_output("b.gapped.cnt", 32'(b_cnt), 2);

    // Short frame then a complete restart
    apply_stimulus_b(1'b1, 1'b1, 12'h400);
    check_write("b.short0", b_wea, b_addra, b_dina, b_done, b_err, 1, 0, 12'h400, 0, 0);
    for (int i = 1; i < 3; i++) begin
      apply_stimulus_b(1'b1, 1'b0, 12'h400 + 12'(i));
      check_write("b.short_px", b_wea, b_addra, b_dina, b_done, b_err, 1, i, 12'h400 + i, 0, 0);
    end
    apply_stimulus_b(1'b1, 1'b1, 12'h410);
    check_write("b.short_err", b_wea, b_addra, b_dina, b_done, b_err, 1, 0, 12'h410, 0, 1);
    check_output("b.short_err.cnt", 32'(b_cnt), 2);
    for (int i = 1; i < 4; i++) begin
      apply_stimulus_b(1'b1, 1'b0, 12'h410 + 12'(i));
      check_write("b.resync", b_wea, b_addra, b_dina, b_done, b_err, 1, i, 12'h410 + i, i == 3, 0);
    end
    check_output("b.resync.cnt", 32'(b_cnt), 3);

    // Enable gating: disarmed frame is ignored
    b_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus_b(1'b1, i == 0, 12'h500 + 12'(i));
      check_output("b.disarmed.wea", 32'(b_wea), 0);
    end
    check_output("b.disarmed.cnt", 32'(b_cnt), 3);
    check_output("b.disarmed.busy", 32'(b_busy), 0);

    // Dropping enable mid-frame does not stop the frame
    b_enable = 1'b1;
    apply_stimulus_b(1'b1, 1'b1, 12'h600);
    check_write("b.armed0", b_wea, b_addra, b_dina, b_done, b_err, 1, 0, 12'h600, 0, 0);
    b_enable = 1'b0;
    for (int i = 1; i < 4; i++) begin
      apply_stimulus_b(1'b1, 1'b0, 12'h600 + 12'(i));
      check_write("b.dropped", b_wea, b_addra, b_dina, b_done, b_err, 1, i, 12'h600 + i, i == 3, 0);
    end
    check_output("b.dropped.cnt", 32'(b_cnt), 4);
    apply_stimulus_b(1'b1, 1'b1, 12'h6FF);
    check_write("b.sof_disarmed", b_wea, b_addra, b_dina, b_done, b_err, 0, 3, 12'h603, 0, 0);
    check_output("b.sof_disarmed.busy", 32'(b_busy), 0);

    // Counter wrap: 252 more frames bring the count from 4 to 256 = 0
    b_enable = 1'b1;
    for (int f = 0; f < 252; f++) begin
      for (int i = 0; i < 4; i++) begin
        apply_stimulus_b(1'b1, i == 0, 12'(f));
      end
      if (f == 250) begin
        check_output("b.wrap.cnt255", 32'(b_cnt), 255);
      end
    end
    check_write("b.wrap.last", b_wea, b_addra, b_dina, b_done, b_err, 1, 3, 251, 1, 0);
    check_output("b.wrap.cnt0", 32'(b_cnt), 0);
    apply_stimulus_b(1'b0, 1'b0, 12'h000);

    $display("[TB] directed sequence complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write-side master for the 320x240 RGB444 frame buffer BRAM (17-bit address, 12-bit data, 76800 words), driving port A of blk_mem_gen_0 in write mode.
- Accepts a pixel stream with a start-of-frame marker from the video receive path.
- Generates sequential write addresses 0..FRAME_PIXELS-1, detects frame completion and malformed frames, and counts completed frames.
- The display read path consumes the buffer independently on the other port.

Parameters:
- ADDR_WIDTH, 17, BRAM address width.
- DATA_WIDTH, 12, pixel width (RGB444).
- FRAME_PIXELS, 76800, pixels per frame (320x240); last address = FRAME_PIXELS-1.
- CNT_WIDTH, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  arm capture; sampled only in IDLE.
- s_data  in  DATA_WIDTH  pixel data.
- s_valid  in  1  pixel valid.
- s_sof  in  1  first pixel of frame; qualified by s_valid.
- s_ready  out  1  writer can accept a pixel.
- wea  out  1  BRAM write enable.
- addra  out  ADDR_WIDTH  BRAM write address.
- dina  out  DATA_WIDTH  BRAM write data.
- busy  out  1  high in WRITE state.
- frame_done  out  1  one-cycle pulse, frame fully written.
- frame_err  out  1  one-cycle pulse, short frame detected.
- frame_cnt  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_ready, wea, busy, frame_done, frame_err = 0; addra, dina, frame_cnt, internal pixel index = 0.
- s_ready: registered; 0 in reset, 1 from the first clock edge after rst_n deasserts, then constant 1. BRAM never back-pressures.
- Accept = s_valid && s_ready.
- IDLE:
  - Accepted pixels without s_sof are discarded (wea=0).
  - Accept with s_sof while enable=1: write the pixel at address 0; index=1; go to WRITE.
  - Accept with s_sof while enable=0: discarded; stay IDLE.
- WRITE:
  - Accept without s_sof: write at address = index; index += 1.
  - If the written address is FRAME_PIXELS-1: frame_done=1 on the same cycle as that write; frame_cnt += 1; index=0; go to IDLE. The next frame needs a new s_sof.
  - Accept with s_sof while index != 0 (short frame): frame_err pulses; write the pixel at address 0; index=1; stay in WRITE. frame_cnt unchanged.
  - enable has no effect in WRITE; the frame in progress always completes.
- Write latency: wea/addra/dina are registered and asserted on the clock edge after the accepting edge (1 cycle). wea=1 for exactly one cycle per written pixel.
  - addra/dina hold their last values when wea=0.
  - frame_done/frame_err are aligned with the wea cycle of the triggering pixel.
- s_valid gaps in WRITE: no writes, index holds; no timeout.
- busy = (state==WRITE), registered together with the state.
- Index and address never exceed FRAME_PIXELS-1; no write is ever issued at address >= FRAME_PIXELS.
- rst_n assertion mid-frame: immediate return to reset values. The partially written buffer contents are not cleared.

Test Plan:
- Reset/ready: hold rst_n=0 for 3 cycles, release -> all outputs 0 during reset; s_ready=1 one edge after release; wea stays 0 with no stimulus.
- Full frame: enable=1; stream 76800 pixels back-to-back, data=index[11:0], s_sof on the first -> 76800 wea pulses at addra 0..76799 with dina=addr[11:0]; frame_done on the addra=76799 cycle; frame_cnt=1; busy falls the cycle after.
- Gaps and pre-SOF junk: 5 valid pixels without s_sof, then a frame with s_valid toggling 1/0 -> the first 5 pixels produce no wea; addresses stay contiguous across gaps; frame_done after 76800 accepted pixels.
- Short frame: s_sof, 100 pixels, then s_sof again, then 76799 more pixels -> frame_err pulse with the addra=0 rewrite; frame_done once at 76799; frame_cnt=1.
- Enable gating: enable=0 with a frame sent -> no writes, frame_cnt unchanged. Drop enable mid-frame -> the frame completes, then an s_sof is ignored.
- Counter wrap and async reset: 256 tiny frames via FRAME_PIXELS=4 override -> frame_cnt wraps to 0. Assert rst_n at index 10 -> outputs 0 immediately; the next s_sof restarts at addra=0.
